// File: rtl/io_seq_pkg.sv
// Shared types and helpers for the IO sequence checker: FSM states,
// verdict codes and the sequence-length clamp.
package io_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  localparam logic [1:0] FC_NONE       = 2'd0;
  localparam logic [1:0] FC_TIMEOUT    = 2'd1;
  localparam logic [1:0] FC_UNEXPECTED = 2'd2;

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
    return (len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/io_stable_filter.sv
// Two-flop synchroniser followed by a stability counter; the accepted value
// only moves once the synchronised sample has been steady long enough.
module io_stable_filter #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_accepted
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             w_same;
  logic [CW-1:0]    w_cnt_next;

  assign w_same = (r_sync2 == r_prev);

  // Counter saturates so a long-steady input keeps reloading the same value.
  assign w_cnt_next = !w_same ? '0 :
                      (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_cnt   <= w_cnt_next;
      if (w_cnt_next == CNT_MAX) r_acc <= r_sync2;
    end
  end

  assign o_accepted = r_acc;

endmodule

// File: rtl/io_seq_checker.sv
// Matches debounced IO pins against a programmable ordered pattern table and
// reports a single pass / fail / timeout verdict per run.
module io_seq_checker
  import io_seq_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 4,
  parameter int STABLE_CYCLES = 2,
  parameter int TIMER_W       = 16,
  parameter int STRICT        = 1
) (
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_i,
  input  logic                             enable,
  input  logic [WIDTH-1:0]                 io_in,
  input  logic [WIDTH-1:0]                 mask,
  input  logic                             exp_wr_en,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] exp_wr_addr,
  input  logic [WIDTH-1:0]                 exp_wr_data,
  input  logic [$clog2(DEPTH+1)-1:0]       seq_len,
  input  logic [TIMER_W-1:0]               timeout_cycles,
  output logic                             busy,
  output logic                             pass,
  output logic                             fail,
  output logic [1:0]                       fail_code,
  output logic [$clog2(DEPTH+1)-1:0]       match_idx,
  output logic [WIDTH-1:0]                 accepted,
  output logic [1:0]                       dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH+1);

  state_t           r_state;
  logic             r_en_d;
  logic             r_busy;
  logic             r_pass;
  logic             r_fail;
  logic [1:0]       r_code;
  logic [LW-1:0]    r_match_idx;
  logic [TIMER_W-1:0] r_timer;
  logic [WIDTH-1:0] r_tab [DEPTH];

  logic [WIDTH-1:0] w_accepted;
  logic [LW-1:0]    w_len;
  logic [LW-1:0]    w_prev_idx;
  logic [LW-1:0]    w_match_next;
  logic [WIDTH-1:0] w_cur;
  logic [WIDTH-1:0] w_prev;
  logic             w_hit;
  logic             w_unexp;
  logic             w_timeout;
  logic             w_start;
  logic             w_tab_we;

  io_stable_filter #(
    .WIDTH         (WIDTH),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .i_clk      (wb_clk_i),
    .i_rst      (wb_rst_i),
    .i_raw      (io_in),
    .o_accepted (w_accepted)
  );

  assign w_len        = LW'(clamp_len(32'(seq_len), DEPTH));
  assign w_prev_idx   = r_match_idx - 1'b1;
  assign w_match_next = r_match_idx + 1'b1;
  assign w_cur        = r_tab[r_match_idx[AW-1:0]];
  assign w_prev       = r_tab[w_prev_idx[AW-1:0]];
  assign w_hit        = (((w_accepted ^ w_cur) & mask) == '0);
  // The pattern just matched may linger; anything else stable is a deviation.
  assign w_unexp      = (STRICT != 0) && (r_match_idx != '0) &&
                        (((w_accepted ^ w_prev) & mask) != '0);
  assign w_timeout    = (timeout_cycles != '0) && (r_timer == timeout_cycles - 1'b1);
  assign w_start      = enable & ~r_en_d;
  assign w_tab_we     = exp_wr_en & ~r_busy;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < DEPTH; i++) r_tab[i] <= '0;
    end else if (w_tab_we) begin
      r_tab[exp_wr_addr] <= exp_wr_data;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= IDLE;
      r_en_d      <= 1'b0;
      r_busy      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_code      <= FC_NONE;
      r_match_idx <= '0;
      r_timer     <= '0;
    end else begin
      r_en_d <= enable;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state     <= RUN;
            r_busy      <= 1'b1;
            r_match_idx <= '0;
            r_timer     <= '0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_code      <= FC_NONE;
          end
        end
        RUN: begin
          if (!enable) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (r_match_idx >= w_len) begin
            r_state <= PASS;
            r_busy  <= 1'b0;
            r_pass  <= 1'b1;
          end else if (w_hit) begin
            r_match_idx <= w_match_next;
            r_timer     <= '0;
            if (w_match_next == w_len) begin
              r_state <= PASS;
              r_busy  <= 1'b0;
              r_pass  <= 1'b1;
            end
          end else if (w_unexp) begin
            r_state <= FAIL;
            r_busy  <= 1'b0;
            r_fail  <= 1'b1;
            r_code  <= FC_UNEXPECTED;
          end else if (w_timeout) begin
            r_state <= FAIL;
            r_busy  <= 1'b0;
            r_fail  <= 1'b1;
            r_code  <= FC_TIMEOUT;
          end else if (r_timer != '1) begin
            r_timer <= r_timer + 1'b1;
          end
        end
        PASS, FAIL: begin
          if (!enable) begin
            r_state <= IDLE;
            r_pass  <= 1'b0;
            r_fail  <= 1'b0;
            r_code  <= FC_NONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign pass      = r_pass;
  assign fail      = r_fail;
  assign fail_code = r_code;
  assign match_idx = r_match_idx;
  assign accepted  = w_accepted;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_io_seq_checker.sv
// Directed bench for io_seq_checker: a vector table of single runs plus
// hand-timed sequences for debounce latency, timeouts, strictness and reset.
module tb_io_seq_checker;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [7:0]  io_in;
  logic [7:0]  mask;
  logic        exp_wr_en;
  logic [1:0]  exp_wr_addr;
  logic [7:0]  exp_wr_data;
  logic [2:0]  seq_len;
  logic [15:0] timeout_cycles;

  logic        busy, pass, fail;
  logic [1:0]  fail_code;
  logic [2:0]  match_idx;
  logic [7:0]  accepted;
  logic [1:0]  dbg_state;

  logic        l_busy, l_pass, l_fail;
  logic [1:0]  l_fail_code;
  logic [2:0]  l_match_idx;
  logic [7:0]  l_accepted;
  logic [1:0]  l_dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic [7:0] mask;
    logic [7:0] pat;
    logic [7:0] pin;
    logic [2:0] len;
    logic       exp_pass;
    logic       exp_fail;
    logic [1:0] exp_code;
    logic [2:0] exp_idx;
  } vec_t;

  vec_t vecs[8];

  io_seq_checker #(.WIDTH(8), .DEPTH(4), .STABLE_CYCLES(2), .TIMER_W(16), .STRICT(1)) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .enable(enable), .io_in(io_in), .mask(mask),
    .exp_wr_en(exp_wr_en), .exp_wr_addr(exp_wr_addr), .exp_wr_data(exp_wr_data),
    .seq_len(seq_len), .timeout_cycles(timeout_cycles),
    .busy(busy), .pass(pass), .fail(fail), .fail_code(fail_code),
    .match_idx(match_idx), .accepted(accepted), .dbg_state(dbg_state)
  );

  io_seq_checker #(.WIDTH(8), .DEPTH(4), .STABLE_CYCLES(2), .TIMER_W(16), .STRICT(0)) u_lax (
    .wb_clk_i(clk), .wb_rst_i(rst), .enable(enable), .io_in(io_in), .mask(mask),
    .exp_wr_en(exp_wr_en), .exp_wr_addr(exp_wr_addr), .exp_wr_data(exp_wr_data),
    .seq_len(seq_len), .timeout_cycles(timeout_cycles),
    .busy(l_busy), .pass(l_pass), .fail(l_fail), .fail_code(l_fail_code),
    .match_idx(l_match_idx), .accepted(l_accepted), .dbg_state(l_dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic write_tab(input logic [1:0] addr, input logic [7:0] data);
    exp_wr_en   = 1'b1;
    exp_wr_addr = addr;
    exp_wr_data = data;
    tick(1);
    exp_wr_en   = 1'b0;
  endtask

  task automatic load_ramp();
    write_tab(2'd0, 8'h01);
    write_tab(2'd1, 8'h03);
    write_tab(2'd2, 8'h07);
    write_tab(2'd3, 8'h0F);
  endtask

  task automatic set_pins(input logic [7:0] v);
    io_in = v;
    tick(6);
  endtask

  task automatic start_run();
    enable = 1'b1;
    tick(1);
  endtask

  task automatic stop_run();
    enable = 1'b0;
    tick(1);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; io_in = 8'h00; mask = 8'hFF;
    exp_wr_en = 1'b0; exp_wr_addr = 2'd0; exp_wr_data = 8'h00;
    seq_len = 3'd0; timeout_cycles = 16'd0;

    vecs[0] = '{8'hFF, 8'hA1, 8'hA1, 3'd1, 1'b1, 1'b0, 2'd0, 3'd1};
    vecs[1] = '{8'h0F, 8'hA1, 8'hF1, 3'd1, 1'b1, 1'b0, 2'd0, 3'd1};
    vecs[2] = '{8'hF0, 8'hA1, 8'hF1, 3'd1, 1'b0, 1'b1, 2'd1, 3'd0};
    vecs[3] = '{8'h00, 8'hA1, 8'h5C, 3'd2, 1'b1, 1'b0, 2'd0, 3'd2};
    vecs[4] = '{8'hFF, 8'h77, 8'h00, 3'd0, 1'b1, 1'b0, 2'd0, 3'd0};
    vecs[5] = '{8'hFF, 8'h3C, 8'h3C, 3'd7, 1'b1, 1'b0, 2'd0, 3'd4};
    vecs[6] = '{8'h0F, 8'h12, 8'hF2, 3'd5, 1'b1, 1'b0, 2'd0, 3'd4};
    vecs[7] = '{8'hFF, 8'h80, 8'h00, 3'd1, 1'b0, 1'b1, 2'd1, 3'd0};

    // Reset state
    tick(2);
    chk("rst_busy", busy, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail", fail, 0);
    chk("rst_code", fail_code, 0);
    chk("rst_idx", match_idx, 0);
    chk("rst_acc", accepted, 0);
    chk("rst_state", dbg_state, 0);
    rst = 1'b0;
    tick(2);

    // Table-driven single runs
    for (int v = 0; v < 8; v++) begin
      for (int a = 0; a < 4; a++) write_tab(2'(a), vecs[v].pat);
      mask = vecs[v].mask;
      set_pins(vecs[v].pin);
      seq_len = vecs[v].len;
      timeout_cycles = 16'd5;
      start_run();
      tick(8);
      chk($sformatf("vec%0d_pass", v), pass, vecs[v].exp_pass);
      chk($sformatf("vec%0d_fail", v), fail, vecs[v].exp_fail);
      chk($sformatf("vec%0d_code", v), fail_code, vecs[v].exp_code);
      chk($sformatf("vec%0d_idx", v), match_idx, vecs[v].exp_idx);
      stop_run();
      chk($sformatf("vec%0d_clear", v), {pass, fail, fail_code}, 0);
    end

    // Pass path with exact debounce latency per step
    mask = 8'hFF;
    load_ramp();
    set_pins(8'h00);
    seq_len = 3'd4;
    timeout_cycles = 16'd100;
    start_run();
    chk("pp_busy", busy, 1);
    begin
      logic [7:0] pats [4];
      pats = '{8'h01, 8'h03, 8'h07, 8'h0F};
      for (int i = 0; i < 4; i++) begin
        io_in = pats[i];
        tick(4);
        chk($sformatf("pp_before%0d", i), match_idx, i);
        tick(1);
        chk($sformatf("pp_after%0d", i), match_idx, i + 1);
        tick(5);
      end
    end
    chk("pp_pass", pass, 1);
    chk("pp_code", fail_code, 0);
    chk("pp_busy_end", busy, 0);
    stop_run();

    // Debounce: one-cycle glitch is ignored, steady value lands after 3+1 edges
    write_tab(2'd0, 8'h0F);
    set_pins(8'h00);
    seq_len = 3'd1;
    timeout_cycles = 16'd0;
    start_run();
    io_in = 8'h0F;
    tick(1);
    io_in = 8'h00;
    tick(6);
    chk("db_glitch_acc", accepted, 8'h00);
    chk("db_glitch_idx", match_idx, 0);
    io_in = 8'h0F;
    tick(3);
    chk("db_acc_early", accepted, 8'h00);
    tick(1);
    chk("db_acc", accepted, 8'h0F);
    chk("db_idx_early", match_idx, 0);
    tick(1);
    chk("db_idx", match_idx, 1);
    chk("db_pass", pass, 1);
    stop_run();

    // Timeout on the 20th RUN cycle
    load_ramp();
    set_pins(8'h00);
    seq_len = 3'd1;
    timeout_cycles = 16'd20;
    start_run();
    tick(19);
    chk("to_early_fail", fail, 0);
    chk("to_early_busy", busy, 1);
    tick(1);
    chk("to_fail", fail, 1);
    chk("to_code", fail_code, 1);
    chk("to_idx", match_idx, 0);
    chk("to_busy", busy, 0);
    stop_run();

    // Unexpected pattern: strict fails at once, lax only on timeout
    seq_len = 3'd2;
    timeout_cycles = 16'd30;
    start_run();
    io_in = 8'h01;
    tick(5);
    chk("ux_idx1", match_idx, 1);
    io_in = 8'h05;
    tick(4);
    chk("ux_hold_fail", fail, 0);
    tick(1);
    chk("ux_fail", fail, 1);
    chk("ux_code", fail_code, 2);
    chk("ux_idx", match_idx, 1);
    chk("lax_idx", l_match_idx, 1);
    chk("lax_nofail", l_fail, 0);
    tick(24);
    chk("lax_early", l_fail, 0);
    tick(1);
    chk("lax_fail", l_fail, 1);
    chk("lax_code", l_fail_code, 1);
    stop_run();

    // seq_len=0 passes one cycle after start
    seq_len = 3'd0;
    start_run();
    chk("len0_busy", busy, 1);
    chk("len0_pass_early", pass, 0);
    tick(1);
    chk("len0_pass", pass, 1);
    chk("len0_busy_end", busy, 0);
    stop_run();

    // Equal consecutive patterns advance one step per edge
    for (int a = 0; a < 4; a++) write_tab(2'(a), 8'h3C);
    set_pins(8'h3C);
    seq_len = 3'd4;
    start_run();
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      chk($sformatf("eq_idx%0d", i), match_idx, i);
    end
    chk("eq_pass", pass, 1);
    stop_run();

    // Abort mid-run
    load_ramp();
    set_pins(8'h00);
    seq_len = 3'd4;
    timeout_cycles = 16'd100;
    start_run();
    io_in = 8'h01;
    tick(5);
    io_in = 8'h03;
    tick(5);
    chk("ab_idx", match_idx, 2);
    enable = 1'b0;
    tick(1);
    chk("ab_busy", busy, 0);
    chk("ab_pf", {pass, fail}, 0);
    chk("ab_state", dbg_state, 0);

    // Table write during a run is ignored
    set_pins(8'h00);
    seq_len = 3'd1;
    timeout_cycles = 16'd0;
    start_run();
    write_tab(2'd0, 8'h55);
    stop_run();
    set_pins(8'h55);
    timeout_cycles = 16'd10;
    start_run();
    tick(12);
    chk("wbusy_fail", fail, 1);
    chk("wbusy_code", fail_code, 1);
    stop_run();

    // Write on the start edge is used by the run
    enable = 1'b1;
    exp_wr_en = 1'b1; exp_wr_addr = 2'd0; exp_wr_data = 8'h55;
    tick(1);
    exp_wr_en = 1'b0;
    chk("wstart_busy", busy, 1);
    tick(1);
    chk("wstart_idx", match_idx, 1);
    chk("wstart_pass", pass, 1);
    stop_run();

    // Asynchronous reset mid-run
    load_ramp();
    set_pins(8'h01);
    seq_len = 3'd4;
    timeout_cycles = 16'd0;
    start_run();
    tick(2);
    chk("mr_idx", match_idx, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_idx0", match_idx, 0);
    chk("mr_acc", accepted, 0);
    chk("mr_state", dbg_state, 0);
    enable = 1'b0;
    io_in = 8'h00;
    tick(1);
    rst = 1'b0;
    tick(6);
    seq_len = 3'd1;
    start_run();
    tick(1);
    chk("mr_tab_cleared", pass, 1);
    stop_run();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/io_seq_checker.md
Name: io_seq_checker

Overview:
Synthesisable, parametrised on-chip checker for user-project IO pins.
- Synchronises and debounces up to WIDTH IO inputs.
- Matches the filtered value against a programmable sequence of up to DEPTH expected patterns, in order.
- Reports pass, fail or timeout, so firmware or a logic analyser gets one verdict instead of reading raw pin dumps.
- Sits in the user project area, next to the Wishbone register file that programs it.

Parameters:
WIDTH, 8, number of IO channels checked
DEPTH, 4, number of entries in the expected-pattern table
STABLE_CYCLES, 2, consecutive identical synchronised samples required to accept a value (min 1)
TIMER_W, 16, width of the per-step timeout counter
STRICT, 1, 1 = an unexpected stable pattern fails immediately; 0 = only timeout fails

Ports:
wb_clk_i  input  1  system clock
wb_rst_i  input  1  asynchronous active-high reset
enable  input  1  level; rising edge starts a run, low aborts
io_in  input  WIDTH  raw pad inputs (asynchronous)
mask  input  WIDTH  1 = bit participates in compare
exp_wr_en  input  1  write strobe for the expected table
exp_wr_addr  input  $clog2(DEPTH)  table index
exp_wr_data  input  WIDTH  expected pattern
seq_len  input  $clog2(DEPTH+1)  number of steps; values > DEPTH clamp to DEPTH
timeout_cycles  input  TIMER_W  per-step limit; 0 disables timeout
busy  output  1  run in progress
pass  output  1  sticky until enable low or reset
fail  output  1  sticky until enable low or reset
fail_code  output  2  0 none, 1 timeout, 2 unexpected pattern
match_idx  output  $clog2(DEPTH+1)  steps matched so far
accepted  output  WIDTH  current debounced value

Behaviour:
- Reset (async, wb_rst_i=1):
  - FSM goes to IDLE.
  - busy=0, pass=0, fail=0, fail_code=0, match_idx=0, accepted=0, timer=0.
  - Synchroniser flops and the expected table are cleared to 0.
- Filter path:
  - io_in passes through a 2-flop synchroniser.
  - A stability counter increments while the synchronised value equals the previous sample and clears on any change.
  - accepted loads the sample when the count reaches STABLE_CYCLES-1.
  - A pin stable before edge k shows on accepted at edge k+1+STABLE_CYCLES.
- Compare: hit = ((accepted ^ exp[match_idx]) & mask) == 0. A fully zero mask always hits.
- FSM states: IDLE, RUN, PASS, FAIL.
  - IDLE -> RUN on an enable rising edge (registered edge detect).
    - Clears match_idx, timer, pass, fail, fail_code.
    - busy=1 from the following edge.
  - RUN, hit: match_idx++ and timer=0 on the next edge. When the new match_idx == effective seq_len, go to PASS (busy=0, pass=1).
  - RUN, no hit, timeout_cycles != 0, timer == timeout_cycles-1: go to FAIL, fail_code=1.
  - RUN, STRICT=1, no hit, match_idx>0, accepted masked != exp[match_idx-1] masked: go to FAIL, fail_code=2.
    - The previous pattern may persist without penalty.
    - For match_idx=0, any value is tolerated.
  - Priority in the same cycle: hit > unexpected > timeout.
  - Timer saturates at all-ones when timeout is disabled.
  - PASS/FAIL hold until enable=0, then return to IDLE with pass/fail/fail_code cleared on the next edge.
  - enable=0 in RUN: abort to IDLE next edge, busy=0, no verdict.
  - Effective seq_len=0: RUN -> PASS on the first RUN cycle.
- One accepted value matches at most one step per cycle. Consecutive equal expected patterns each require one cycle, so they pass on consecutive edges without a pin change.
- Expected-table writes:
  - Accepted only while busy=0; ignored while busy=1.
  - A write in the same cycle as the start edge is applied; the run reads the table from the next cycle.
- Reset asserted mid-run: immediate return to IDLE with all outputs at reset values. The table is lost.

Decomposition:
- Package io_seq_pkg holds:
  - state enum (IDLE, RUN, PASS, FAIL);
  - fail_code constants FC_NONE=0, FC_TIMEOUT=1, FC_UNEXPECTED=2;
  - a function computing the clamped seq_len.
- Sub-module io_stable_filter (parameters WIDTH, STABLE_CYCLES) holds the synchroniser, stability counter and accepted register.
- io_seq_checker instantiates one io_stable_filter and holds the FSM, table, timer and compare.

Test Plan:
- Pass path: WIDTH=8, table {01,03,07,0F}, seq_len=4, mask=FF, timeout=100; drive the patterns 10 cycles apart -> match_idx 1,2,3,4, pass=1, fail_code=0, busy=0.
- Debounce: STABLE_CYCLES=2; glitch io_in 00->0F for 1 cycle during step 0 expecting 0F -> accepted unchanged, no match; hold 0F for 3 cycles -> match_idx=1 exactly 4 edges after it became stable.
- Timeout: timeout_cycles=20; hold 00 with exp[0]=01 -> fail=1, fail_code=1 on the 20th RUN cycle, match_idx=0.
- Unexpected pattern: STRICT=1; match 01, then drive stable 05 while expecting 03 -> fail_code=2, match_idx=1; with STRICT=0 the same stimulus -> no fail until timeout.
- Mask and seq_len edges: mask=0F, exp[0]=A1, drive F1 -> hit. seq_len=0 -> pass one cycle after start. seq_len=7 with DEPTH=4 -> clamped, passes after 4 matches.
- Abort and reset: deassert enable at match_idx=2 -> IDLE next edge, busy=0, pass=fail=0. A table write with busy=1 is ignored (readback via a rerun fails). Assert wb_rst_i mid-run -> all outputs 0 without a clock edge.
